// File: rtl/fc_layer_bp_engine.sv
// Single-layer FC back-propagation / weight-update engine with saturating fixed point.
// Holds act, W, err_in, delta and err_out; streams err_out to the previous layer.
module fc_layer_bp_engine #(
    parameter int IN_CELL    = 32,
    parameter int OUT_CELL   = 20,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int LR_SHIFT   = 3,
    parameter int BATCH_LOG2 = 5,
    parameter int AW         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        rd_sel,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              bp_start,
    input  logic              upd_start,
    output logic              busy,
    output logic              err_valid,
    input  logic              err_ready,
    output logic [DATA_W-1:0] err_data,
    output logic [AW-1:0]     err_addr,
    output logic              bp_done,
    output logic              upd_done,
    output logic              sat_flag
);
    localparam int NK = IN_CELL * OUT_CELL;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;
    localparam int IW = (IN_CELL > 1) ? $clog2(IN_CELL) : 1;
    localparam int OW = (OUT_CELL > 1) ? $clog2(OUT_CELL) : 1;

    typedef logic signed [DATA_W-1:0] word_t;
    typedef struct packed {
        logic  sat;
        word_t val;
    } sres_t;

    localparam word_t SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam word_t SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_BACK, S_STREAM, S_UPDATE} state_t;

    function automatic sres_t fmul(input word_t a, input word_t b);
        logic signed [2*DATA_W-1:0] p;
        sres_t r;
        p = a * b;
        p = p >>> FRAC_W;
        r.sat = (p[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){p[2*DATA_W-1]}});
        r.val = r.sat ? (p[2*DATA_W-1] ? SMIN : SMAX) : p[DATA_W-1:0];
        return r;
    endfunction

    function automatic sres_t sat_add(input word_t a, input word_t b);
        logic [DATA_W:0] s;
        sres_t r;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        r.sat = s[DATA_W] ^ s[DATA_W-1];
        r.val = r.sat ? (s[DATA_W] ? SMIN : SMAX) : s[DATA_W-1:0];
        return r;
    endfunction

    word_t act_mem   [IN_CELL];
    word_t w_mem     [NK];
    word_t ein_mem   [OUT_CELL];
    word_t delta_mem [NK];
    word_t eo_mem    [IN_CELL];

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q;
    logic [OW-1:0]     i_q;
    logic [IW-1:0]     j_q;
    logic              bp_done_q, upd_done_q, sat_q;
    logic [DATA_W-1:0] rd_data_q;

    logic k_last, i_last, j_last;
    assign k_last = (k_q == KW'(NK - 1));
    assign i_last = (i_q == OW'(OUT_CELL - 1));
    assign j_last = (j_q == IW'(IN_CELL - 1));

    // Datapath: every array read is combinational off the current indices.
    word_t w_k, d_k, act_j, ein_i, eo_j, eo_base, ad_sh, d_sh;
    sres_t m_we, m_ad, a_eo, a_d, a_w;
    always_comb begin
        w_k     = w_mem[k_q];
        d_k     = delta_mem[k_q];
        act_j   = act_mem[j_q];
        ein_i   = ein_mem[i_q];
        eo_j    = eo_mem[j_q];
        m_we    = fmul(w_k, ein_i);
        m_ad    = fmul(act_j, ein_i);
        eo_base = (i_q == '0) ? '0 : eo_j;
        a_eo    = sat_add(eo_base, m_we.val);
        ad_sh   = $signed(m_ad.val) >>> LR_SHIFT;
        a_d     = sat_add(d_k, ad_sh);
        d_sh    = $signed(d_k) >>> BATCH_LOG2;
        a_w     = sat_add(w_k, d_sh);
    end

    logic sat_ev;
    assign sat_ev = ((state_q == S_BACK) && (m_we.sat || m_ad.sat || a_eo.sat || a_d.sat)) ||
                    ((state_q == S_UPDATE) && a_w.sat);

    logic host_we, wr_hit;
    always_comb begin
        wr_hit = 1'b0;
        case (wr_sel)
            2'd0:    wr_hit = (wr_addr < AW'(IN_CELL));
            2'd1:    wr_hit = (wr_addr < AW'(NK));
            2'd2:    wr_hit = (wr_addr < AW'(OUT_CELL));
            default: wr_hit = 1'b0;
        endcase
    end
    assign host_we = wr_en && wr_hit && (state_q == S_IDLE);

    // Array storage is not reset; writes are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (host_we && wr_sel == 2'd0) act_mem[wr_addr[IW-1:0]] <= wr_data;
            if (host_we && wr_sel == 2'd2) ein_mem[wr_addr[OW-1:0]] <= wr_data;
            if (host_we && wr_sel == 2'd1) w_mem[wr_addr[KW-1:0]] <= wr_data;
            else if (state_q == S_UPDATE)  w_mem[k_q] <= a_w.val;
            if (state_q == S_CLEAR || state_q == S_UPDATE) delta_mem[k_q] <= '0;
            else if (state_q == S_BACK)                    delta_mem[k_q] <= a_d.val;
            if (state_q == S_BACK) eo_mem[j_q] <= a_eo.val;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR:  if (k_last) state_d = S_IDLE;
            S_IDLE: begin
                if (bp_start)       state_d = S_BACK;
                else if (upd_start) state_d = S_UPDATE;
            end
            S_BACK:   if (k_last) state_d = S_STREAM;
            S_STREAM: if (err_ready && j_last) state_d = S_IDLE;
            S_UPDATE: if (k_last) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            bp_done_q  <= 1'b0;
            upd_done_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bp_done_q  <= (state_q == S_STREAM) && err_ready && j_last;
            upd_done_q <= (state_q == S_UPDATE) && k_last;
            if (state_q == S_IDLE && bp_start) sat_q <= 1'b0;
            else if (sat_ev)                   sat_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    k_q <= '0;
                    i_q <= '0;
                    j_q <= '0;
                end
                S_CLEAR, S_UPDATE: k_q <= k_last ? '0 : k_q + 1'b1;
                S_BACK: begin
                    k_q <= k_last ? '0 : k_q + 1'b1;
                    j_q <= j_last ? '0 : j_q + 1'b1;
                    if (j_last) i_q <= i_last ? '0 : i_q + 1'b1;
                end
                S_STREAM: if (err_ready) j_q <= j_last ? '0 : j_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= '0;
            case (rd_sel)
                2'd0: if (rd_addr < AW'(IN_CELL))  rd_data_q <= act_mem[rd_addr[IW-1:0]];
                2'd1: if (rd_addr < AW'(NK))       rd_data_q <= w_mem[rd_addr[KW-1:0]];
                2'd2: if (rd_addr < AW'(NK))       rd_data_q <= delta_mem[rd_addr[KW-1:0]];
                2'd3: if (rd_addr < AW'(IN_CELL))  rd_data_q <= eo_mem[rd_addr[IW-1:0]];
                default: ;
            endcase
        end
    end

    // State sits in CLEAR during reset, so busy is masked to keep outputs at 0.
    assign busy      = (state_q != S_IDLE) && !reset;
    assign err_valid = (state_q == S_STREAM);
    assign err_data  = (state_q == S_STREAM) ? eo_j : '0;
    assign err_addr  = (state_q == S_STREAM) ? AW'(j_q) : '0;
    assign bp_done   = bp_done_q;
    assign upd_done  = upd_done_q;
    assign sat_flag  = sat_q;
    assign rd_data   = rd_data_q;
endmodule

// File: doc/fc_layer_bp_engine.md
Name: fc_layer_bp_engine

Overview:
Parametrised single-layer fully-connected back-propagation and weight-update engine. It holds a layer's input activations, weights, incoming output error, accumulated delta weights and computed input error. Instances chain to build multi-layer FC stages: each engine's streamed error output feeds the previous layer's error write port. Compared with the fixed 32/20/10 FC memory, it adds parametrised sizes, fixed-point width and learning rate, saturating arithmetic, a ready/valid error stream and a post-reset delta-clear sweep.

Parameters:
IN_CELL, 32, number of input cells (columns of W)
OUT_CELL, 20, number of output cells (rows of W)
DATA_W, 16, signed fixed-point word width
FRAC_W, 8, fractional bits of every stored word
LR_SHIFT, 3, learning rate = 2^-LR_SHIFT
BATCH_LOG2, 5, mini-batch size = 2^BATCH_LOG2
AW, 16, address width (must cover IN_CELL*OUT_CELL)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  host write strobe; ignored while busy=1
wr_sel  in  2  target region: 0 act[IN_CELL], 1 W[OUT_CELL*IN_CELL] row-major (i*IN_CELL+j), 2 err_in[OUT_CELL], 3 reserved (write dropped)
wr_addr  in  AW  word address within the region; out-of-range writes are dropped
wr_data  in  DATA_W  write data
rd_sel  in  2  read region: 0 act, 1 W, 2 delta, 3 err_out
rd_addr  in  AW  read address
rd_data  out  DATA_W  registered read data, 1-cycle latency; reads 0 when the address is out of range
bp_start  in  1  pulse: run back-propagation for one sample
upd_start  in  1  pulse: apply the batch update
busy  out  1  high in every state except IDLE
err_valid  out  1  err_data/err_addr are valid
err_ready  in  1  downstream accepts the word
err_data  out  DATA_W  computed input error err_out[j]
err_addr  out  AW  j
bp_done  out  1  1-cycle pulse when back-propagation completes
upd_done  out  1  1-cycle pulse when the update completes
sat_flag  out  1  sticky: set on any saturation; cleared by bp_start or reset

Behaviour:
- Reset (asynchronous): every output = 0; the FSM enters CLEAR. Array contents other than delta are not cleared. A reset mid-operation aborts it with no further writes.
- fmul(a,b): full 2*DATA_W product, arithmetic shift right by FRAC_W, saturate to the DATA_W signed range. All additions also saturate. Each saturation event sets sat_flag.
- FSM states: CLEAR, IDLE, BACK, STREAM, UPDATE.
- CLEAR: writes delta[k]=0 for k=0..OUT_CELL*IN_CELL-1, one word per cycle, busy=1, then goes to IDLE.
- IDLE: bp_start has priority over upd_start when both are asserted in the same cycle. Start pulses arriving in any other state are ignored.
- BACK: loop i=0..OUT_CELL-1 (outer), j=0..IN_CELL-1 (inner), one MAC per cycle; total OUT_CELL*IN_CELL cycles.
  - err_out[j] = (i==0 ? 0 : err_out[j]) + fmul(W[i][j], err_in[i])
  - delta[i][j] += fmul(act[j], err_in[i]) >>> LR_SHIFT
- STREAM: for j=0..IN_CELL-1, present err_valid=1 with err_data=err_out[j] and err_addr=j. The index advances only on err_valid&&err_ready. While err_ready=0, the data and address hold stable. After the last handshake: err_valid=0, bp_done pulses, return to IDLE.
- UPDATE: for k=0..OUT_CELL*IN_CELL-1, one word per cycle:
  - W[k] += delta[k] >>> BATCH_LOG2 (saturating)
  - delta[k] = 0
  - After the last word, upd_done pulses and the FSM returns to IDLE.
- Host reads are served in every state. A read of a word being written in the same cycle returns the old value.
- Host writes are accepted only in IDLE. The same-cycle wr_en and bp_start in IDLE: the write lands first, then BACK starts on the next cycle.

Test Plan:
- Reset sweep: IN=2, OUT=2, assert then release reset -> busy=1 for exactly 4 cycles (CLEAR), then 0; rd_sel=2 returns 0 for all four addresses.
- Back-prop, FRAC_W=8, LR_SHIFT=0: act=[256,512], W=[256,0,0,256], err_in=[128,-64], bp_start with err_ready=1 -> busy for 4 BACK cycles, then stream (0,128),(1,-64); bp_done pulses; delta reads [128,256,-64,-128].
- Update: after the back-prop case with BATCH_LOG2=0, upd_start -> after 4 cycles upd_done pulses; W reads [384,256,-64,128]; delta reads all 0.
- Backpressure: hold err_ready=0 for 5 cycles during STREAM -> err_valid=1 and err_data=128, err_addr=0 held stable; no bp_done until both words have handshaken.
- Saturation: W[0]=32767, err_in[0]=32767, act=256 -> err_out[0]=32767 (not wrapped) and sat_flag=1; the next bp_start clears sat_flag.
- Priority/abort: bp_start and upd_start in the same cycle -> BACK runs and UPDATE does not. Assert reset mid-BACK -> all outputs 0, CLEAR re-runs.
